// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus,
// with a watchdog that completes transactions no slave acknowledges.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        owner,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      err_addr_nxt;
  logic             done;
  logic             timeout;
  logic             finish;
  logic [31:0]      resp_data;

  // State, grant and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      err_addr   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      count      <= count_nxt;
      err_addr   <= err_addr_nxt;
    end
  end

  // Arbitration, completion and watchdog decisions
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    count_nxt      = count;
    err_addr_nxt   = err_addr;
    done           = 1'b0;
    timeout        = 1'b0;

    case (state)
      IDLE: begin
        count_nxt = '0;
        if (m0_valid && m1_valid) begin
          owner_nxt = ~last_grant;
          state_nxt = BUSY;
        end else if (m0_valid) begin
          owner_nxt = 1'b0;
          state_nxt = BUSY;
        end else if (m1_valid) begin
          owner_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        // A real acknowledge always beats a simultaneous watchdog expiry
        if (s_ready) begin
          done = 1'b1;
        end else if (count == CNT_LAST) begin
          timeout      = 1'b1;
          err_addr_nxt = s_addr;
        end else begin
          count_nxt = count + CNT_W'(1);
        end

        if (done || timeout) begin
          last_grant_nxt = owner;
          state_nxt      = IDLE;
          count_nxt      = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Downstream request: owner's fields while BUSY, zero otherwise
  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (state == BUSY) begin
      s_valid = 1'b1;
      if (owner) begin
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end else begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
    end
  end

  assign finish    = done || timeout;
  assign resp_data = timeout ? ERR_RDATA : s_rdata;
  assign bus_err   = timeout;

  // Completion is steered only to the owner; read data is zero when not ready
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (finish) begin
      if (owner) begin
        m1_ready = 1'b1;
        m1_rdata = resp_data;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus
// hand sequences for fairness, watchdog, timeout race and mid-transaction reset.
module tb_mem_bus_arbiter;

  localparam logic [31:0] A0 = 32'h0002_0004;
  localparam logic [31:0] A1 = 32'h9000_0000;
  localparam logic [31:0] WD0 = 32'h0BAD_F00D;
  localparam logic [31:0] WD1 = 32'hCAFE_0001;
  localparam int NVEC = 13;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        owner, bus_err;
  logic [31:0] err_addr;

  int n_vec;
  int n_err;

  mem_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .m0_valid (m0_valid),
    .m0_instr (m0_instr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (m1_valid),
    .m1_instr (m1_instr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .owner    (owner),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        sr;
    logic [31:0] srd;
    logic        e_sv;
    logic        e_own;
    logic        e_r0;
    logic        e_r1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_saddr;
  } vec_t;

  vec_t vt [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next negedge; inputs change there, outputs checked 2ns later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1,
                       input logic sr, input logic [31:0] srd);
    reset    = rst;
    m0_valid = v0;
    m1_valid = v1;
    s_ready  = sr;
    s_rdata  = srd;
  endtask

  task automatic do_reset();
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = A0; m0_wdata = WD0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = A1; m1_wdata = WD1; m1_wstrb = 4'hF;
    s_ready = 1'b0;
    s_rdata = 32'h0;

    //          rst  v0   v1   sr   srd           sv   own  r0   r1   rd0           rd1           saddr
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[2]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        A0};
    vt[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        A0};
    vt[5]  = '{1'b0,1'b1,1'b0,1'b1,32'h1234_5678,1'b1,1'b0,1'b1,1'b0,32'h1234_5678,32'h0,        A0};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[9]  = '{1'b0,1'b1,1'b1,1'b1,32'h0000_000A,1'b1,1'b0,1'b1,1'b0,32'h0000_000A,32'h0,        A0};
    vt[10] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0};
    vt[11] = '{1'b0,1'b0,1'b1,1'b1,32'h0000_000B,1'b1,1'b1,1'b0,1'b1,32'h0,        32'h0000_000B,A1};
    vt[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0};

    // Single-master read and tie-after-reset, one row per clock cycle
    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      drive(vt[i].rst, vt[i].v0, vt[i].v1, vt[i].sr, vt[i].srd);
      settle();
      check($sformatf("v%0d s_valid", i), 32'(s_valid), 32'(vt[i].e_sv));
      check($sformatf("v%0d owner", i), 32'(owner), 32'(vt[i].e_own));
      check($sformatf("v%0d m0_ready", i), 32'(m0_ready), 32'(vt[i].e_r0));
      check($sformatf("v%0d m1_ready", i), 32'(m1_ready), 32'(vt[i].e_r1));
      check($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].e_rd0);
      check($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].e_rd1);
      check($sformatf("v%0d s_addr", i), s_addr, vt[i].e_saddr);
      check($sformatf("v%0d bus_err", i), 32'(bus_err), 32'h0);
    end

    // Fairness: both masters always requesting, slave answers immediately
    do_reset();
    for (int t = 0; t < 8; t++) begin
      if (t != 0) next_cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(t));
      settle();
      check($sformatf("fair%0d idle s_valid", t), 32'(s_valid), 32'h0);
      next_cycle();
      settle();
      check($sformatf("fair%0d owner", t), 32'(owner), 32'(t % 2));
      check($sformatf("fair%0d m0_ready", t), 32'(m0_ready), 32'((t % 2) == 0));
      check($sformatf("fair%0d m1_ready", t), 32'(m1_ready), 32'((t % 2) == 1));
    end

    // Watchdog: m1 write to an unmapped address never acknowledged
    do_reset();
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      next_cycle();
      settle();
      if (k < 64) begin
        if (m1_ready !== 1'b0 || bus_err !== 1'b0)
          check($sformatf("wd busy%0d early", k), {30'h0, m1_ready, bus_err}, 32'h0);
      end else begin
        check("wd m1_ready", 32'(m1_ready), 32'h1);
        check("wd bus_err", 32'(bus_err), 32'h1);
        check("wd m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("wd s_addr", s_addr, A1);
        check("wd s_wdata", s_wdata, WD1);
        check("wd s_wstrb", 32'(s_wstrb), 32'hF);
        check("wd m0_ready", 32'(m0_ready), 32'h0);
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    check("wd idle s_valid", 32'(s_valid), 32'h0);
    check("wd err_addr", err_addr, A1);
    check("wd bus_err drop", 32'(bus_err), 32'h0);

    // Timeout race: ack lands in the same cycle the watchdog would fire
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      next_cycle();
      if (k == 64) drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h55AA_33CC);
      settle();
      if (k == 64) begin
        check("race m0_ready", 32'(m0_ready), 32'h1);
        check("race m0_rdata", m0_rdata, 32'h55AA_33CC);
        check("race bus_err", 32'(bus_err), 32'h0);
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    check("race err_addr kept", err_addr, A1);

    // Reset in BUSY cycle 2 of an m0 write abandons it silently
    do_reset();
    m0_wstrb = 4'hF;
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    settle();
    check("rst busy1 s_wstrb", 32'(s_wstrb), 32'hF);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    check("rst s_valid", 32'(s_valid), 32'h0);
    check("rst m0_ready", 32'(m0_ready), 32'h0);
    check("rst m1_ready", 32'(m1_ready), 32'h0);
    check("rst err_addr", err_addr, 32'h0);
    m0_wstrb = 4'h0;
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h77);
    next_cycle();
    settle();
    check("rst tie owner", 32'(owner), 32'h0);
    check("rst tie m0_ready", 32'(m0_ready), 32'h1);
    check("rst tie m1_ready", 32'(m1_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
